// File: rtl/conv_window_sequencer.sv
// Frame controller for the kernelWindow 3x3 generator: latches layer geometry, resets the
// window, streams NHWC beats with optional zero border and emits aligned position tags.
module conv_window_sequencer #(
  parameter int DATA_W         = 64,
  parameter int DIM_W          = 16,
  parameter int WIN_RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_in_channels,
  input  logic [DIM_W-1:0]  cfg_img_width,
  input  logic [DIM_W-1:0]  cfg_img_height,
  input  logic              cfg_pad,
  output logic              busy,
  output logic              frame_done,
  output logic              cfg_err,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  input  logic              ds_ready,
  output logic              win_rst,
  output logic              win_data_valid,
  output logic [DATA_W-1:0] win_pixel,
  output logic [DIM_W-1:0]  win_in_channels,
  output logic [DIM_W-1:0]  win_img_width,
  output logic              tag_valid,
  output logic [DIM_W-1:0]  tag_row,
  output logic [DIM_W-1:0]  tag_col,
  output logic [DIM_W-1:0]  tag_cg
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRST = 2'd1, S_STREAM = 2'd2, S_DRAIN = 2'd3} state_t;

  localparam logic [DIM_W-1:0] ONE      = DIM_W'(1);
  localparam logic [DIM_W-1:0] TWO      = DIM_W'(2);
  localparam logic [DIM_W:0]   MIN_DIM  = (DIM_W+1)'(3);
  localparam logic [7:0]       RST_LAST = 8'(WIN_RST_CYCLES - 1);

  state_t state_q, state_d;
  logic busy_q, busy_d, frame_done_q, frame_done_d, cfg_err_q, cfg_err_d, win_rst_q, win_rst_d;
  logic win_valid_q, win_valid_d, pad_q, pad_d, drain_q, drain_d;
  logic t1_valid_q, t1_valid_d, tag_valid_q, tag_valid_d;
  logic [DATA_W-1:0] win_pixel_q, win_pixel_d;
  logic [DIM_W-1:0] in_ch_q, in_ch_d, wp_q, wp_d, hp_q, hp_d, grp_q, grp_d;
  logic [DIM_W-1:0] r_q, r_d, c_q, c_d, g_q, g_d;
  logic [DIM_W-1:0] t1_row_q, t1_row_d, t1_col_q, t1_col_d, t1_cg_q, t1_cg_d;
  logic [DIM_W-1:0] tag_row_q, tag_row_d, tag_col_q, tag_col_d, tag_cg_q, tag_cg_d;
  logic [7:0] rst_cnt_q, rst_cnt_d;

  logic [DIM_W:0] pad2_s, wp_ext_s, hp_ext_s;
  logic cfg_legal_s, pad_pos_s, fire_s, last_g_s, last_c_s, last_r_s;

  // Geometry checks, border detection and beat handshake
  always_comb begin
    pad2_s      = '0;
    pad2_s[1]   = cfg_pad;
    wp_ext_s    = {1'b0, cfg_img_width} + pad2_s;
    hp_ext_s    = {1'b0, cfg_img_height} + pad2_s;
    cfg_legal_s = (cfg_in_channels != '0) && (cfg_in_channels[2:0] == 3'd0) &&
                  (wp_ext_s >= MIN_DIM) && (hp_ext_s >= MIN_DIM);
    pad_pos_s   = pad_q && ((r_q == '0) || (r_q == hp_q - ONE) || (c_q == '0) || (c_q == wp_q - ONE));
    fire_s      = (state_q == S_STREAM) && ds_ready && (pad_pos_s || src_valid);
    src_ready   = (state_q == S_STREAM) && ds_ready && !pad_pos_s;
    last_g_s    = (g_q == grp_q - ONE);
    last_c_s    = (c_q == wp_q - ONE);
    last_r_s    = (r_q == hp_q - ONE);
  end

  // Next-state computation for the controller, counters and output pipeline
  always_comb begin
    state_d = state_q;   busy_d = busy_q;     frame_done_d = 1'b0; cfg_err_d = cfg_err_q;
    in_ch_d = in_ch_q;   wp_d = wp_q;         hp_d = hp_q;         grp_d = grp_q;
    pad_d   = pad_q;     r_d = r_q;           c_d = c_q;           g_d = g_q;
    rst_cnt_d = rst_cnt_q; drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_legal_s) begin
            state_d   = S_WRST;
            busy_d    = 1'b1;
            cfg_err_d = 1'b0;
            in_ch_d   = cfg_in_channels;
            wp_d      = wp_ext_s[DIM_W-1:0];
            hp_d      = hp_ext_s[DIM_W-1:0];
            grp_d     = cfg_in_channels >> 3;
            pad_d     = cfg_pad;
            r_d = '0; c_d = '0; g_d = '0;
            rst_cnt_d = 8'd0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_STREAM;
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      S_STREAM: begin
        if (fire_s) begin
          // g innermost, then c, then r
          if (last_g_s) begin
            g_d = '0;
            if (last_c_s) begin
              c_d = '0;
              if (last_r_s) begin
                r_d     = '0;
                state_d = S_DRAIN;
                drain_d = 1'b0;
              end else begin
                r_d = r_q + ONE;
              end
            end else begin
              c_d = c_q + ONE;
            end
          end else begin
            g_d = g_q + ONE;
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DRAIN: begin
        if (drain_q) begin
          state_d      = S_IDLE;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    win_rst_d   = (state_d == S_IDLE) || (state_d == S_WRST);
    win_valid_d = fire_s;
    if (fire_s) begin
      win_pixel_d = pad_pos_s ? '0 : src_data;
    end else begin
      win_pixel_d = win_pixel_q;
    end

    // Two-stage tag pipeline lines up with kernelWindow's one-cycle dout_valid
    t1_valid_d = fire_s && (r_q >= TWO) && (c_q >= TWO);
    if (t1_valid_d) begin
      t1_row_d = r_q - TWO; t1_col_d = c_q - TWO; t1_cg_d = g_q;
    end else begin
      t1_row_d = t1_row_q;  t1_col_d = t1_col_q;  t1_cg_d = t1_cg_q;
    end
    tag_valid_d = t1_valid_q;
    if (t1_valid_q) begin
      tag_row_d = t1_row_q;  tag_col_d = t1_col_q;  tag_cg_d = t1_cg_q;
    end else begin
      tag_row_d = tag_row_q; tag_col_d = tag_col_q; tag_cg_d = tag_cg_q;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;   busy_q <= 1'b0;   frame_done_q <= 1'b0; cfg_err_q <= 1'b0;
      win_rst_q <= 1'b1;   win_valid_q <= 1'b0; win_pixel_q <= '0;
      in_ch_q <= '0; wp_q <= '0; hp_q <= '0; grp_q <= '0; pad_q <= 1'b0;
      r_q <= '0; c_q <= '0; g_q <= '0; rst_cnt_q <= 8'd0; drain_q <= 1'b0;
      t1_valid_q <= 1'b0; t1_row_q <= '0; t1_col_q <= '0; t1_cg_q <= '0;
      tag_valid_q <= 1'b0; tag_row_q <= '0; tag_col_q <= '0; tag_cg_q <= '0;
    end else begin
      state_q <= state_d;   busy_q <= busy_d;   frame_done_q <= frame_done_d; cfg_err_q <= cfg_err_d;
      win_rst_q <= win_rst_d; win_valid_q <= win_valid_d; win_pixel_q <= win_pixel_d;
      in_ch_q <= in_ch_d; wp_q <= wp_d; hp_q <= hp_d; grp_q <= grp_d; pad_q <= pad_d;
      r_q <= r_d; c_q <= c_d; g_q <= g_d; rst_cnt_q <= rst_cnt_d; drain_q <= drain_d;
      t1_valid_q <= t1_valid_d; t1_row_q <= t1_row_d; t1_col_q <= t1_col_d; t1_cg_q <= t1_cg_d;
      tag_valid_q <= tag_valid_d; tag_row_q <= tag_row_d; tag_col_q <= tag_col_d; tag_cg_q <= tag_cg_d;
    end
  end

  assign busy            = busy_q;
  assign frame_done      = frame_done_q;
  assign cfg_err         = cfg_err_q;
  assign win_rst         = win_rst_q;
  assign win_data_valid  = win_valid_q;
  assign win_pixel       = win_pixel_q;
  assign win_in_channels = in_ch_q;
  assign win_img_width   = wp_q;
  assign tag_valid       = tag_valid_q;
  assign tag_row         = tag_row_q;
  assign tag_col         = tag_col_q;
  assign tag_cg          = tag_cg_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed self-checking bench for conv_window_sequencer: frames with and without padding,
// multi-group channels, source/downstream stalls, illegal config and mid-frame reset.
module tb_conv_window_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_in_channels = 16'd0;
  logic [15:0] cfg_img_width = 16'd0;
  logic [15:0] cfg_img_height = 16'd0;
  logic        cfg_pad = 1'b0;
  logic        busy, frame_done, cfg_err;
  logic        src_valid = 1'b0;
  logic [63:0] src_data = 64'd0;
  logic        src_ready;
  logic        ds_ready = 1'b0;
  logic        win_rst, win_data_valid;
  logic [63:0] win_pixel;
  logic [15:0] win_in_channels, win_img_width;
  logic        tag_valid;
  logic [15:0] tag_row, tag_col, tag_cg;

  int n_tests = 0;
  int n_fail  = 0;

  conv_window_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_in_channels(cfg_in_channels), .cfg_img_width(cfg_img_width),
    .cfg_img_height(cfg_img_height), .cfg_pad(cfg_pad),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .ds_ready(ds_ready), .win_rst(win_rst), .win_data_valid(win_data_valid),
    .win_pixel(win_pixel), .win_in_channels(win_in_channels), .win_img_width(win_img_width),
    .tag_valid(tag_valid), .tag_row(tag_row), .tag_col(tag_col), .tag_cg(tag_cg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] src_word(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i + 1);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {busy, frame_done, cfg_err, src_ready, win_data_valid, tag_valid, win_rst}, 64'b0000001);
    check({tag, "_data"}, win_pixel | {win_in_channels, win_img_width, tag_row, tag_col} | {48'd0, tag_cg}, 64'd0);
  endtask

  task automatic run_frame(input logic [15:0] ch, input logic [15:0] w, input logic [15:0] h,
                           input logic pd, input bit toggle_src, input bit stall_ds, input int abort_beats);
    int g  = int'(ch) >> 3;
    int wp = int'(w) + 2 * int'(pd);
    int hp = int'(h) + 2 * int'(pd);
    int k = 0, sent = 0, done = 0, zeros = 0, bad = 0, srdy_bad = 0, stall_bad = 0;
    int stall_left = 5, first_tag_cyc = -1, key_beat_cyc = -1, key_beat;
    bit pend = 1'b0, ds_low_prev = 1'b0, fin = 1'b0, pad_here;
    logic [63:0] exp_pix[$];
    logic [47:0] exp_tag[$];
    logic [63:0] got_pix[$];
    logic [47:0] got_tag[$];
    key_beat = (2 * wp + 2) * g + 1;
    for (int r = 0; r < hp; r++)
      for (int c = 0; c < wp; c++)
        for (int gg = 0; gg < g; gg++) begin
          pad_here = pd && (r == 0 || r == hp - 1 || c == 0 || c == wp - 1);
          if (pad_here) exp_pix.push_back(64'd0);
          else begin
            exp_pix.push_back(src_word(k));
            k++;
          end
          if (r >= 2 && c >= 2) exp_tag.push_back({16'(r - 2), 16'(c - 2), 16'(gg)});
        end

    @(negedge clk);
    cfg_in_channels = ch; cfg_img_width = w; cfg_img_height = h; cfg_pad = pd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("cfg_err_cleared", cfg_err, 1'b0);
    check("win_img_width", win_img_width, 64'(wp));
    check("win_in_channels", win_in_channels, ch);

    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      if (pend) sent++;
      pend = 1'b0;
      if (win_data_valid) begin
        got_pix.push_back(win_pixel);
        if (win_pixel == 64'd0) zeros++;
        if (got_pix.size() == key_beat) key_beat_cyc = cyc;
        if (ds_low_prev) stall_bad++;
      end
      if (tag_valid) begin
        got_tag.push_back({tag_row, tag_col, tag_cg});
        if (first_tag_cyc < 0) first_tag_cyc = cyc;
      end
      if (frame_done) begin
        done++;
        fin = 1'b1;
      end
      if (abort_beats > 0 && got_pix.size() == abort_beats) begin
        rst_n = 1'b0; src_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        rst_n = 1'b1;
        done = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (frame_done || busy) done++;
        end
        check("abort_no_frame_done", 64'(done), 64'd0);
        return;
      end
      src_valid = toggle_src ? ((cyc % 2) == 0) : 1'b1;
      src_data  = src_word(sent);
      if (stall_ds && got_pix.size() >= 6 && stall_left > 0) begin
        ds_ready = 1'b0;
        stall_left--;
      end else begin
        ds_ready = 1'b1;
      end
      ds_low_prev = !ds_ready;
      #1;
      if (src_ready && src_valid) pend = 1'b1;
      if (src_ready && !ds_ready) srdy_bad++;
      @(negedge clk);
    end
    src_valid = 1'b0;

    check("frame_done_seen", 64'(done), 64'd1);
    check("beat_count", 64'(got_pix.size()), 64'(hp * wp * g));
    check("src_consumed", 64'(sent), 64'(int'(h) * int'(w) * g));
    check("zero_beats", 64'(zeros), 64'(hp * wp * g - int'(h) * int'(w) * g));
    check("tag_count", 64'(got_tag.size()), 64'((hp - 2) * (wp - 2) * g));
    for (int i = 0; i < got_pix.size() && i < exp_pix.size(); i++)
      if (got_pix[i] !== exp_pix[i]) bad++;
    check("pixel_sequence", 64'(bad), 64'd0);
    bad = 0;
    for (int i = 0; i < got_tag.size() && i < exp_tag.size(); i++)
      if (got_tag[i] !== exp_tag[i]) bad++;
    check("tag_sequence", 64'(bad), 64'd0);
    check("first_tag_latency", 64'(first_tag_cyc), 64'(key_beat_cyc + 1));
    check("src_ready_without_ds", 64'(srdy_bad), 64'd0);
    if (stall_ds) check("stall_no_beats", 64'(stall_bad), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("idle_after_frame", {busy, frame_done, win_rst}, 64'b001);
  endtask

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    run_frame(16'd8, 16'd4, 16'd4, 1'b0, 1'b0, 1'b0, 0);
    run_frame(16'd8, 16'd4, 16'd4, 1'b1, 1'b0, 1'b0, 0);
    run_frame(16'd16, 16'd4, 16'd4, 1'b0, 1'b0, 1'b0, 0);
    run_frame(16'd8, 16'd4, 16'd4, 1'b0, 1'b1, 1'b1, 0);

    // Illegal channel count: error flag only, window stays in reset
    @(negedge clk);
    cfg_in_channels = 16'd12; cfg_img_width = 16'd4; cfg_img_height = 16'd4; cfg_pad = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("illegal_cfg_err", cfg_err, 1'b1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy || !win_rst || !cfg_err) bad++;
    end
    check("illegal_stays_idle", 64'(bad), 64'd0);
    run_frame(16'd8, 16'd4, 16'd4, 1'b0, 1'b0, 1'b0, 0);

    // Smallest legal frame: 1x1 with border gives a 3x3 padded image
    run_frame(16'd8, 16'd1, 16'd1, 1'b1, 1'b0, 1'b0, 0);

    run_frame(16'd8, 16'd4, 16'd4, 1'b0, 1'b0, 1'b0, 7);
    run_frame(16'd8, 16'd4, 16'd4, 1'b0, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
Frame-level controller that sequences the kernelWindow 3x3 window generator for one convolution layer pass. It latches the layer geometry, resets the window generator, and streams NHWC pixel vectors (8 channels per 64-bit beat) from a valid/ready source into the window. It inserts optional zero padding and emits a position tag (out_row, out_col, out_cg) aligned with each valid window output.

Parameters:
DATA_W, 64, pixel vector width (8 ch x 8 bit)
DIM_W, 16, width of dimension/channel config fields
WIN_RST_CYCLES, 2, cycles win_rst is held high before streaming

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE
cfg_in_channels  in  DIM_W  input channels; multiple of 8, nonzero
cfg_img_width  in  DIM_W  unpadded width W
cfg_img_height  in  DIM_W  unpadded height H
cfg_pad  in  1  1 = one-pixel zero border on all sides
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse at frame end
cfg_err  out  1  sticky illegal-config flag; cleared by next legal start
src_valid  in  1  source vector valid
src_data  in  DATA_W  source vector
src_ready  out  1  source vector accepted this cycle
ds_ready  in  1  downstream MAC able to take a window this cycle
win_rst  out  1  active-high reset to kernelWindow
win_data_valid  out  1  beat to kernelWindow
win_pixel  out  DATA_W  beat data
win_in_channels  out  DIM_W  latched cfg_in_channels
win_img_width  out  DIM_W  padded width Wp
tag_valid  out  1  a window is valid this cycle; aligned with kernelWindow dout_valid
tag_row  out  DIM_W  output row
tag_col  out  DIM_W  output column
tag_cg  out  DIM_W  channel group of the window

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. All outputs 0, except win_rst=1. Counters cleared. cfg_err=0. Reset mid-frame aborts immediately with no frame_done.
- Derived values, latched at start: G = cfg_in_channels>>3; Wp = W+2*pad; Hp = H+2*pad.
- Config is illegal if any of these hold: cfg_in_channels==0; cfg_in_channels[2:0]!=0; Wp<3; Hp<3. An illegal start sets cfg_err, stays in IDLE and never raises busy.
- States:
  - IDLE: a legal start goes to WRST and sets busy=1.
  - WRST: win_rst=1 for WIN_RST_CYCLES cycles, then go to STREAM.
  - STREAM: beats are issued until the last one, then go to DRAIN.
  - DRAIN: wait 2 cycles for the final tag, pulse frame_done, clear busy, go to IDLE.
  - start is ignored outside IDLE.
- Counters: r in [0,Hp), c in [0,Wp), g in [0,G). g is innermost, c next, r outermost. Wrap to 0 at each limit.
- pad_pos = cfg_pad && (r==0 || r==Hp-1 || c==0 || c==Wp-1).
- Beat fires in STREAM when ds_ready && (pad_pos || src_valid).
- src_ready = STREAM && ds_ready && !pad_pos (combinational).
- A pad beat sends all-zero data and does not consume the source.
- A beat that does not fire advances no counters and issues no beat. A stall produces a gap; beats are never duplicated.
- Latency: win_data_valid and win_pixel are registered 1 cycle after fire. tag_valid and the tag fields are registered 2 cycles after fire, matching kernelWindow's 1-cycle dout_valid.
- tag_valid is set for a fired beat with r>=2 && c>=2. Then tag_row=r-2, tag_col=c-2, tag_cg=g.
- Tags per frame = (Hp-2)*(Wp-2)*G.
- Total beats = Hp*Wp*G; source beats consumed = H*W*G.
- Simultaneous last-beat fire and a new start: start is ignored, because state is not IDLE.
- Held outputs: win_in_channels and win_img_width are held from start until the next legal start. Tag fields hold their last value when tag_valid=0.

Test Plan:
- W=H=4, ch=8, pad=0, src always valid, ds_ready=1:
  - 16 beats, 16 src_ready.
  - 4 tags (0,0,0),(0,1,0),(1,0,0),(1,1,0).
  - First tag 2 cycles after 11th fire (r=2,c=2).
  - One frame_done; busy low afterward.
- W=H=4, ch=8, pad=1:
  - win_img_width=6; 36 beats.
  - Exactly 20 zero beats with src_ready=0, 16 source beats consumed.
  - 16 tags covering rows 0..3 and cols 0..3.
- W=H=4, ch=16, pad=0:
  - 32 beats; 8 tags with tag_cg alternating 0,1.
  - First tag at r=2,c=2,g=0.
- Source stalls: src_valid toggled 50% in the 4x4/8ch case.
  - win_pixel sequence equals the source order with no repeats.
  - 4 tags; src_ready never high while src_valid=0 causes loss.
  - ds_ready held low 5 cycles mid-row: no beats, no counter advance.
- cfg_in_channels=12, start:
  - cfg_err=1, busy stays 0, no win_rst deassert sequence.
  - A following legal start clears cfg_err and runs normally.
- rst_n=0 asserted after 7 beats of a 4x4 frame:
  - Next cycle all outputs 0 (win_rst=1), no frame_done.
  - A new start runs a full correct frame.
